// File: rtl/bus_burst_read_master_if.sv
// ---------------------------------------------------------------------------
// bus_burst_read_master_if
// Groups the shared-bus signals and the output word stream of the burst read
// master.
//   Bus, master -> responder/arbiter : requestBusOut, beginTransactionOut,
//       addressDataOut[31:0], byteEnablesOut[3:0], readNotWriteOut,
//       burstSizeOut[7:0]
//   Bus, responder/arbiter -> master : busGrantIn, addressDataIn[31:0],
//       dataValidIn, endTransactionIn, busErrorIn
//   Stream, master -> consumer       : streamDataOut[31:0], streamValidOut
//   Stream, consumer -> master       : streamReadyIn
// The master modport is the view of bus_burst_read_master. The slave modport
// is the view of the surrounding system (arbiter, responder and consumer).
// ---------------------------------------------------------------------------
interface bus_burst_read_master_if;
    logic        requestBusOut;
    logic        busGrantIn;
    logic        beginTransactionOut;
    logic [31:0] addressDataOut;
    logic [3:0]  byteEnablesOut;
    logic        readNotWriteOut;
    logic [7:0]  burstSizeOut;
    logic [31:0] addressDataIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic        busErrorIn;
    logic [31:0] streamDataOut;
    logic        streamValidOut;
    logic        streamReadyIn;

    modport master (
        output requestBusOut, beginTransactionOut, addressDataOut, byteEnablesOut,
               readNotWriteOut, burstSizeOut, streamDataOut, streamValidOut,
        input  busGrantIn, addressDataIn, dataValidIn, endTransactionIn,
               busErrorIn, streamReadyIn
    );

    modport slave (
        input  requestBusOut, beginTransactionOut, addressDataOut, byteEnablesOut,
               readNotWriteOut, burstSizeOut, streamDataOut, streamValidOut,
        output busGrantIn, addressDataIn, dataValidIn, endTransactionIn,
               busErrorIn, streamReadyIn
    );
endinterface

// File: rtl/bus_burst_read_master.sv
// ---------------------------------------------------------------------------
// bus_burst_read_master
// Shared-bus initiator that reads wordCountIn 32-bit words starting at
// startAddressIn using read bursts of at most MAX_BURST words, buffers them
// in a first-word-fall-through FIFO and delivers them on a valid/ready stream.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   startIn             one-cycle start pulse (accepted only when idle)
//   startAddressIn[31:0] byte address of the first word (bits [1:0] ignored)
//   wordCountIn[15:0]   number of words to fetch
//   activeOut           a job is in progress
//   doneOut             one-cycle pulse when a job finishes or aborts
//   errorOut            sticky bus error flag, cleared by the next start
//   bus                 bus + stream signals (bus_burst_read_master_if.master)
// ---------------------------------------------------------------------------
module bus_burst_read_master #(
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          startIn,
    input  logic [31:0]                   startAddressIn,
    input  logic [15:0]                   wordCountIn,
    output logic                          activeOut,
    output logic                          doneOut,
    output logic                          errorOut,
    bus_burst_read_master_if.master       bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQUEST, BEGIN, READ} state_t;

    state_t      state_q, state_d;
    logic [31:0] address_q, address_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] rxCount_q, rxCount_d;
    logic        error_q, error_d;
    logic        done_q, done_d;
    logic        release_q, release_d;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;

    logic [15:0]      burstWords;
    logic [CNT_W-1:0] freeSpace;
    logic             burstFits;
    logic             requestBus;
    logic             beginStrobe;
    logic             push;
    logic             pop;

    // Size of the next burst and whether the FIFO can absorb it completely;
    // the request is withheld until it can, so the FIFO never overflows.
    always_comb begin
        burstWords = (remaining_q > 16'(MAX_BURST)) ? 16'(MAX_BURST) : remaining_q;
        freeSpace  = CNT_W'(FIFO_DEPTH) - count_q;
        burstFits  = 16'(freeSpace) >= burstWords;
    end

    // Job sequencing. release_q forces one cycle without request after each
    // completed burst so the arbiter can hand the bus to another client.
    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        remaining_d = remaining_q;
        rxCount_d   = rxCount_q;
        error_d     = error_q;
        done_d      = 1'b0;
        release_d   = 1'b0;
        requestBus  = 1'b0;
        beginStrobe = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (startIn) begin
                    address_d   = startAddressIn & 32'hFFFF_FFFC;
                    remaining_d = wordCountIn;
                    error_d     = 1'b0;
                    if (wordCountIn == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = REQUEST;
                    end
                end
            end
            REQUEST: begin
                requestBus = !release_q && burstFits;
                if (requestBus && bus.busGrantIn) begin
                    state_d = BEGIN;
                end
            end
            BEGIN: begin
                requestBus  = 1'b1;
                beginStrobe = 1'b1;
                rxCount_d   = 16'd0;
                state_d     = READ;
            end
            READ: begin
                requestBus = 1'b1;
                if (bus.busErrorIn) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Surplus words beyond the requested burst length are dropped.
                    if (bus.dataValidIn && (rxCount_q < burstWords)) begin
                        push      = 1'b1;
                        rxCount_d = rxCount_q + 16'd1;
                    end
                    if (bus.endTransactionIn) begin
                        remaining_d = remaining_q - burstWords;
                        address_d   = address_q + {16'd0, burstWords[13:0], 2'b00};
                        if (remaining_d == 16'd0) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            release_d = 1'b1;
                            state_d   = REQUEST;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            address_q   <= '0;
            remaining_q <= '0;
            rxCount_q   <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            remaining_q <= remaining_d;
            rxCount_q   <= rxCount_d;
            error_q     <= error_d;
            done_q      <= done_d;
            release_q   <= release_d;
        end
    end

    assign pop = (count_q != '0) && bus.streamReadyIn;

    // FIFO bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage has no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr_q] <= bus.addressDataIn;
        end
    end

    noPushWhenFull: assert property (@(posedge clock) disable iff (reset)
        !(push && (count_q == CNT_W'(FIFO_DEPTH))));

    // The bus is wired-OR, so every field except the request is zero outside BEGIN.
    assign bus.requestBusOut       = requestBus;
    assign bus.beginTransactionOut = beginStrobe;
    assign bus.addressDataOut      = beginStrobe ? address_q : 32'd0;
    assign bus.byteEnablesOut      = beginStrobe ? 4'hF : 4'h0;
    assign bus.readNotWriteOut     = beginStrobe;
    assign bus.burstSizeOut        = beginStrobe ? 8'(burstWords - 16'd1) : 8'd0;
    assign bus.streamValidOut      = (count_q != '0);
    assign bus.streamDataOut       = (count_q != '0) ? mem[rdPtr_q] : 32'd0;

    assign activeOut = (state_q != IDLE);
    assign doneOut   = done_q;
    assign errorOut  = error_q;

endmodule

// File: tb/tb_bus_burst_read_master.sv
// ---------------------------------------------------------------------------
// tb_bus_burst_read_master
// Directed bench for bus_burst_read_master: acts as arbiter, responder and
// stream consumer, and compares against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_bus_burst_read_master;

    logic        clock;
    logic        reset;
    logic        startIn;
    logic [31:0] startAddressIn;
    logic [15:0] wordCountIn;
    logic        activeOut;
    logic        doneOut;
    logic        errorOut;

    bus_burst_read_master_if busIf ();

    bus_burst_read_master #(.MAX_BURST(16), .FIFO_DEPTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .startIn        (startIn),
        .startAddressIn (startAddressIn),
        .wordCountIn    (wordCountIn),
        .activeOut      (activeOut),
        .doneOut        (doneOut),
        .errorOut       (errorOut),
        .bus            (busIf)
    );

    int          checks = 0;
    int          failures = 0;
    int          doneCount = 0;
    int          beginCount = 0;
    int          wordSeq = 0;
    logic [31:0] recvQ[$];
    logic [31:0] expQ[$];

    // Free-running clock, 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Consumer and event monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (busIf.streamValidOut && busIf.streamReadyIn) recvQ.push_back(busIf.streamDataOut);
            if (doneOut) doneCount++;
            if (busIf.beginTransactionOut) beginCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] count);
        @(posedge clock); #1;
        startIn        = 1'b1;
        startAddressIn = addr;
        wordCountIn    = count;
        @(posedge clock); #1;
        startIn = 1'b0;
    endtask

    // Grants the bus, checks the begin cycle, then returns nWords data words
    // (ending the burst on the last one) or raises busErrorIn on word errAt.
    task automatic serveBurst(input string tag, input logic [31:0] expAddr, input logic [7:0] expSize,
                              input int nWords, input int errAt);
        bit seen = 1'b0;
        busIf.busGrantIn = 1'b1;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clock);
            if (busIf.beginTransactionOut) seen = 1'b1;
        end
        busIf.busGrantIn = 1'b0;
        if (!seen) begin
            checkOutput({tag, "_beginTimeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, "_addr"}, busIf.addressDataOut, expAddr);
        checkOutput({tag, "_size"}, {24'd0, busIf.burstSizeOut}, {24'd0, expSize});
        checkOutput({tag, "_rnwBe"}, {27'd0, busIf.readNotWriteOut, busIf.byteEnablesOut}, 32'h1F);
        for (int i = 0; i < nWords; i++) begin
            @(posedge clock); #1;
            if (i == 0) checkOutput({tag, "_addrIdle"}, busIf.addressDataOut, 32'd0);
            busIf.dataValidIn   = 1'b1;
            busIf.addressDataIn = 32'hD000_0000 + 32'(wordSeq);
            wordSeq++;
            if (i == errAt) begin
                busIf.busErrorIn = 1'b1;
                break;
            end
            expQ.push_back(busIf.addressDataIn);
            busIf.endTransactionIn = (i == nWords - 1);
        end
        @(posedge clock); #1;
        busIf.dataValidIn      = 1'b0;
        busIf.endTransactionIn = 1'b0;
        busIf.busErrorIn       = 1'b0;
        busIf.addressDataIn    = 32'd0;
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, "_nWords"}, 32'(recvQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < recvQ.size(); i++) begin
            checkOutput($sformatf("%s_word%0d", tag, i), recvQ[i], expQ[i]);
        end
        recvQ.delete();
        expQ.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int baseDone;
        int baseBegin;
        bit seen;
        reset                  = 1'b1;
        startIn                = 1'b0;
        startAddressIn         = 32'd0;
        wordCountIn            = 16'd0;
        busIf.busGrantIn       = 1'b0;
        busIf.addressDataIn    = 32'd0;
        busIf.dataValidIn      = 1'b0;
        busIf.endTransactionIn = 1'b0;
        busIf.busErrorIn       = 1'b0;
        busIf.streamReadyIn    = 1'b1;

        // Reset state.
        waitCycles(2);
        checkOutput("rst_ctrl", {29'd0, activeOut, doneOut, errorOut}, 32'd0);
        checkOutput("rst_bus", {30'd0, busIf.requestBusOut, busIf.beginTransactionOut}, 32'd0);
        checkOutput("rst_stream", {31'd0, busIf.streamValidOut}, 32'd0);
        reset = 1'b0;
        waitCycles(2);

        // T1: single short burst, consumer always ready.
        baseDone = doneCount; baseBegin = beginCount;
        applyStimulus(32'h0000_0100, 16'd5);
        checkOutput("T1_active", {31'd0, activeOut}, 32'd1);
        serveBurst("T1", 32'h0000_0100, 8'd4, 5, -1);
        waitCycles(10);
        checkOutput("T1_done", 32'(doneCount - baseDone), 32'd1);
        checkOutput("T1_begins", 32'(beginCount - baseBegin), 32'd1);
        checkOutput("T1_idle", {30'd0, activeOut, errorOut}, 32'd0);
        checkStream("T1");

        // T2: 40 words split as 16 / 16 / 8.
        baseDone = doneCount; baseBegin = beginCount;
        applyStimulus(32'h0000_0003, 16'd40);
        serveBurst("T2b1", 32'h0000_0000, 8'd15, 16, -1);
        checkOutput("T2_reqDrop", {31'd0, busIf.requestBusOut}, 32'd0);
        serveBurst("T2b2", 32'h0000_0040, 8'd15, 16, -1);
        checkOutput("T2_noEarlyDone", 32'(doneCount - baseDone), 32'd0);
        serveBurst("T2b3", 32'h0000_0080, 8'd7, 8, -1);
        waitCycles(40);
        checkOutput("T2_done", 32'(doneCount - baseDone), 32'd1);
        checkOutput("T2_begins", 32'(beginCount - baseBegin), 32'd3);
        checkStream("T2");

        // T3: consumer stalled, FIFO fills after two bursts.
        busIf.streamReadyIn = 1'b0;
        baseDone = doneCount; baseBegin = beginCount;
        applyStimulus(32'h0000_0000, 16'd40);
        serveBurst("T3b1", 32'h0000_0000, 8'd15, 16, -1);
        serveBurst("T3b2", 32'h0000_0040, 8'd15, 16, -1);
        waitCycles(4);
        checkOutput("T3_reqGated", {31'd0, busIf.requestBusOut}, 32'd0);
        checkOutput("T3_fifoValid", {31'd0, busIf.streamValidOut}, 32'd1);
        @(posedge clock); #1; busIf.streamReadyIn = 1'b1;
        repeat (7) @(posedge clock);
        #1; busIf.streamReadyIn = 1'b0;
        waitCycles(2);
        checkOutput("T3_popped7", 32'(recvQ.size()), 32'd7);
        checkOutput("T3_reqAfter7", {31'd0, busIf.requestBusOut}, 32'd0);
        checkOutput("T3_begins2", 32'(beginCount - baseBegin), 32'd2);
        @(posedge clock); #1; busIf.streamReadyIn = 1'b1;
        repeat (9) @(posedge clock);
        #1; busIf.streamReadyIn = 1'b0;
        serveBurst("T3b3", 32'h0000_0080, 8'd7, 8, -1);
        busIf.streamReadyIn = 1'b1;
        waitCycles(40);
        checkOutput("T3_done", 32'(doneCount - baseDone), 32'd1);
        checkStream("T3");

        // T4: bus error on the third data word of the first burst.
        busIf.streamReadyIn = 1'b0;
        baseDone = doneCount; baseBegin = beginCount;
        applyStimulus(32'h0000_2000, 16'd10);
        serveBurst("T4", 32'h0000_2000, 8'd9, 10, 2);
        waitCycles(10);
        checkOutput("T4_error", {31'd0, errorOut}, 32'd1);
        checkOutput("T4_done", 32'(doneCount - baseDone), 32'd1);
        checkOutput("T4_begins", 32'(beginCount - baseBegin), 32'd1);
        checkOutput("T4_idle", {30'd0, activeOut, busIf.requestBusOut}, 32'd0);
        busIf.streamReadyIn = 1'b1;
        waitCycles(6);
        checkOutput("T4_errorSticky", {31'd0, errorOut}, 32'd1);
        checkStream("T4");

        // T5: zero-length job, then a restart attempt during an active job.
        baseDone = doneCount;
        applyStimulus(32'h0000_1234, 16'd0);
        checkOutput("T5_zeroDone", {31'd0, doneOut}, 32'd1);
        checkOutput("T5_zeroQuiet", {29'd0, busIf.requestBusOut, activeOut, errorOut}, 32'd0);
        @(posedge clock); #1;
        checkOutput("T5_donePulse", {31'd0, doneOut}, 32'd0);
        waitCycles(3);
        checkOutput("T5_zeroNoReq", {31'd0, busIf.requestBusOut}, 32'd0);
        applyStimulus(32'h0000_3000, 16'd3);
        waitCycles(2);
        applyStimulus(32'h0000_9000, 16'd7);
        serveBurst("T5", 32'h0000_3000, 8'd2, 3, -1);
        waitCycles(10);
        checkOutput("T5_done", 32'(doneCount - baseDone), 32'd2);
        checkStream("T5");

        // T6: asynchronous reset in the middle of a burst.
        busIf.streamReadyIn = 1'b0;
        applyStimulus(32'h0000_0400, 16'd4);
        busIf.busGrantIn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clock);
            if (busIf.beginTransactionOut) seen = 1'b1;
        end
        busIf.busGrantIn = 1'b0;
        checkOutput("T6_begin", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            busIf.dataValidIn   = 1'b1;
            busIf.addressDataIn = 32'hEEEE_0000 + 32'(i);
        end
        @(posedge clock); #1;
        busIf.dataValidIn = 1'b0;
        @(negedge clock);
        checkOutput("T6_preValid", {30'd0, busIf.streamValidOut, busIf.requestBusOut}, 32'd3);
        #2 reset = 1'b1;
        #1;
        checkOutput("T6_rstReq", {31'd0, busIf.requestBusOut}, 32'd0);
        checkOutput("T6_rstCtrl", {29'd0, activeOut, doneOut, errorOut}, 32'd0);
        checkOutput("T6_rstStream", {31'd0, busIf.streamValidOut}, 32'd0);
        checkOutput("T6_rstData", busIf.streamDataOut, 32'd0);
        recvQ.delete();
        expQ.delete();
        #3 reset = 1'b0;
        busIf.streamReadyIn = 1'b1;
        baseDone = doneCount;
        applyStimulus(32'h0000_0500, 16'd2);
        serveBurst("T6", 32'h0000_0500, 8'd1, 2, -1);
        waitCycles(10);
        checkOutput("T6_done", 32'(doneCount - baseDone), 32'd1);
        checkStream("T6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
